// File: rtl/estimador_func_demux_21_3_seq_if.sv
// Bundle for the 1:3 word demultiplexer: one valid/ready input stream
// and three valid/ready output channels, plus frame and select-error status.
interface estimador_func_demux_21_3_seq_if #(
   parameter int DATA_WIDTH = 21,
   parameter int SEL_WIDTH  = 2
);
   logic [DATA_WIDTH-1:0] din;
   logic [SEL_WIDTH-1:0]  din_sel;
   logic                  din_seq_mode;
   logic                  din_vld;
   logic                  din_rdy;

   logic [DATA_WIDTH-1:0] dout0;
   logic [DATA_WIDTH-1:0] dout1;
   logic [DATA_WIDTH-1:0] dout2;
   logic                  dout0_vld;
   logic                  dout1_vld;
   logic                  dout2_vld;
   logic                  dout0_rdy;
   logic                  dout1_rdy;
   logic                  dout2_rdy;

   logic                  frame_done;
   logic                  err_sel;

   // Producer side: drives the input word and the consumer ready lines.
   modport master (
      output din, din_sel, din_seq_mode, din_vld,
      input  din_rdy,
      input  dout0, dout1, dout2, dout0_vld, dout1_vld, dout2_vld,
      output dout0_rdy, dout1_rdy, dout2_rdy,
      input  frame_done, err_sel
   );

   // Demultiplexer side.
   modport slave (
      input  din, din_sel, din_seq_mode, din_vld,
      output din_rdy,
      output dout0, dout1, dout2, dout0_vld, dout1_vld, dout2_vld,
      input  dout0_rdy, dout1_rdy, dout2_rdy,
      output frame_done, err_sel
   );
endinterface

// File: rtl/estimador_func_demux_21_3_seq.sv
// 1:3 demultiplexer scattering a serialized 21-bit state vector onto three
// 1-deep holding channels, routed by explicit select or by an internal sequencer.
module estimador_func_demux_21_3_seq #(
   parameter int DATA_WIDTH = 21,
   parameter int SEL_WIDTH  = 2
) (
   input logic                              ap_clk,
   input logic                              ap_rst_n,
   estimador_func_demux_21_3_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      SEQ_CH0 = 2'd0,
      SEQ_CH1 = 2'd1,
      SEQ_CH2 = 2'd2
   } seq_state_t;

   seq_state_t                   seq_state_p1;
   seq_state_t                   seq_next;

   logic signed [DATA_WIDTH-1:0] chan_data_p1 [3];
   logic [2:0]                   chan_vld_p1;
   logic [2:0]                   chan_rdy;
   logic [2:0]                   chan_free;
   logic                         frame_done_p1;
   logic                         err_sel_p1;

   logic [1:0]                   target;
   logic                         target_free;
   logic                         din_rdy_c;
   logic                         xfer;
   logic                         sel_bad;

   // Decode must stay identical to the companion 3:1 mux: sel[1] wins, so 3 maps to channel 2.
   function automatic logic [1:0] decode_target(input logic                 seq_mode,
                                                input logic [SEL_WIDTH-1:0] sel,
                                                input seq_state_t           st);
      logic [1:0] t;
      if (seq_mode)
         t = st;
      else if (sel[1])
         t = 2'd2;
      else if (sel[0])
         t = 2'd1;
      else
         t = 2'd0;
      return t;
   endfunction

   assign chan_rdy  = {bus.dout2_rdy, bus.dout1_rdy, bus.dout0_rdy};
   assign chan_free = ~chan_vld_p1 | chan_rdy;
   assign target    = decode_target(bus.din_seq_mode, bus.din_sel, seq_state_p1);

   always_comb begin
      target_free = 1'b0;
      case (target)
         2'd0:    target_free = chan_free[0];
         2'd1:    target_free = chan_free[1];
         default: target_free = chan_free[2];
      endcase
   end

   assign din_rdy_c = ap_rst_n & target_free;
   assign xfer      = bus.din_vld & din_rdy_c;
   assign sel_bad   = ~bus.din_seq_mode & (bus.din_sel == SEL_WIDTH'(3));

   always_comb begin
      seq_next = seq_state_p1;
      if (!bus.din_seq_mode) begin
         seq_next = SEQ_CH0;
      end else if (xfer) begin
         case (seq_state_p1)
            SEQ_CH0: seq_next = SEQ_CH1;
            SEQ_CH1: seq_next = SEQ_CH2;
            default: seq_next = SEQ_CH0;
         endcase
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)
         seq_state_p1 <= SEQ_CH0;
      else
         seq_state_p1 <= seq_next;
   end

   // Stage p0 -> p1: load the target channel, drain the others independently.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int k = 0; k < 3; k++) begin
            chan_data_p1[k] <= '0;
         end
         chan_vld_p1   <= '0;
         frame_done_p1 <= 1'b0;
         err_sel_p1    <= 1'b0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (xfer && (target == k[1:0])) begin
               chan_data_p1[k] <= bus.din;
               chan_vld_p1[k]  <= 1'b1;
            end else if (chan_vld_p1[k] && chan_rdy[k]) begin
               chan_vld_p1[k]  <= 1'b0;
            end
         end
         frame_done_p1 <= xfer & bus.din_seq_mode & (seq_state_p1 == SEQ_CH2);
         if (xfer && sel_bad)
            err_sel_p1 <= 1'b1;
      end
   end

   assign bus.din_rdy    = din_rdy_c;
   assign bus.dout0      = chan_data_p1[0];
   assign bus.dout1      = chan_data_p1[1];
   assign bus.dout2      = chan_data_p1[2];
   assign bus.dout0_vld  = chan_vld_p1[0];
   assign bus.dout1_vld  = chan_vld_p1[1];
   assign bus.dout2_vld  = chan_vld_p1[2];
   assign bus.frame_done = frame_done_p1;
   assign bus.err_sel    = err_sel_p1;

endmodule

// File: tb/tb_estimador_func_demux_21_3_seq.sv
// Directed-vector bench for the 1:3 estimator demultiplexer.
module tb_estimador_func_demux_21_3_seq;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   pulses;

   estimador_func_demux_21_3_seq_if #(.DATA_WIDTH(21), .SEL_WIDTH(2)) bus ();

   estimador_func_demux_21_3_seq #(.DATA_WIDTH(21), .SEL_WIDTH(2)) dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dout_of(input int k);
      case (k)
         0:       return 32'(bus.dout0);
         1:       return 32'(bus.dout1);
         default: return 32'(bus.dout2);
      endcase
   endfunction

   function automatic logic vld_of(input int k);
      case (k)
         0:       return bus.dout0_vld;
         1:       return bus.dout1_vld;
         default: return bus.dout2_vld;
      endcase
   endfunction

   task automatic put(input logic [20:0] d, input logic [1:0] sel, input logic mode);
      bus.din          = d;
      bus.din_sel      = sel;
      bus.din_seq_mode = mode;
      bus.din_vld      = 1'b1;
   endtask

   task automatic set_rdy(input logic r);
      bus.dout0_rdy = r;
      bus.dout1_rdy = r;
      bus.dout2_rdy = r;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      pulses = 0;
      rst_n = 1'b0;
      bus.din = '0;
      bus.din_sel = '0;
      bus.din_seq_mode = 1'b0;
      bus.din_vld = 1'b0;
      set_rdy(1'b1);
      step();
      step();
      chk("rst_vld0", 32'(bus.dout0_vld), 32'd0);
      chk("rst_dout2", 32'(bus.dout2), 32'd0);
      chk("rst_din_rdy", 32'(bus.din_rdy), 32'd0);
      chk("rst_err", 32'(bus.err_sel), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("idle_din_rdy_no_vld", 32'(bus.din_rdy), 32'd1);

      // direct mode, one word per channel
      put(21'h00001, 2'd0, 1'b0);
      #1 chk("d0_rdy", 32'(bus.din_rdy), 32'd1);
      step();
      chk("d0_dout0", dout_of(0), 32'h1);
      chk("d0_vld0", 32'(vld_of(0)), 32'd1);
      put(21'h00002, 2'd1, 1'b0);
      step();
      chk("d1_dout1", dout_of(1), 32'h2);
      chk("d1_vld1", 32'(vld_of(1)), 32'd1);
      chk("d1_vld0_drained", 32'(vld_of(0)), 32'd0);
      put(21'h00003, 2'd2, 1'b0);
      step();
      chk("d2_dout2", dout_of(2), 32'h3);
      chk("d2_vld2", 32'(vld_of(2)), 32'd1);
      chk("d2_err", 32'(bus.err_sel), 32'd0);

      // sel=3 routes to channel 2 and sets sticky error
      put(21'h1ABCD, 2'd3, 1'b0);
      step();
      chk("s3_dout2", dout_of(2), 32'h1ABCD);
      chk("s3_vld2", 32'(vld_of(2)), 32'd1);
      chk("s3_err", 32'(bus.err_sel), 32'd1);
      put(21'h00005, 2'd0, 1'b0);
      step();
      chk("s3_err_sticky", 32'(bus.err_sel), 32'd1);
      chk("s3_next_dout0", dout_of(0), 32'h5);
      bus.din_vld = 1'b0;
      rst_n = 1'b0;
      #1 chk("s3_err_cleared", 32'(bus.err_sel), 32'd0);
      step();
      rst_n = 1'b1;

      // sequence mode, two full frames; select is ignored here
      for (int i = 0; i < 6; i++) begin
         put(21'(32'h10 + i), 2'd3, 1'b1);
         step();
         chk("seq_dout", dout_of(i % 3), 32'h10 + 32'(i));
         chk("seq_vld", 32'(vld_of(i % 3)), 32'd1);
         chk("seq_frame", 32'(bus.frame_done), (i % 3 == 2) ? 32'd1 : 32'd0);
         if (bus.frame_done) pulses++;
      end
      bus.din_vld = 1'b0;
      step();
      chk("seq_frame_end", 32'(bus.frame_done), 32'd0);
      chk("seq_pulses", 32'(pulses), 32'd2);
      chk("seq_err_ignored", 32'(bus.err_sel), 32'd0);

      // backpressure on channel 1
      bus.din_seq_mode = 1'b0;
      bus.dout1_rdy = 1'b0;
      put(21'h0AAAA, 2'd1, 1'b0);
      step();
      chk("bp_fill", dout_of(1), 32'h0AAAA);
      put(21'h0BBBB, 2'd1, 1'b0);
      #1 chk("bp_stall_rdy", 32'(bus.din_rdy), 32'd0);
      step();
      chk("bp_hold_dout1", dout_of(1), 32'h0AAAA);
      chk("bp_hold_vld1", 32'(vld_of(1)), 32'd1);
      put(21'h0CCCC, 2'd0, 1'b0);
      #1 chk("bp_other_rdy", 32'(bus.din_rdy), 32'd1);
      step();
      chk("bp_other_dout0", dout_of(0), 32'h0CCCC);
      chk("bp_other_keep1", dout_of(1), 32'h0AAAA);
      put(21'h0BBBB, 2'd1, 1'b0);
      bus.dout1_rdy = 1'b1;
      #1 chk("bp_refill_rdy", 32'(bus.din_rdy), 32'd1);
      step();
      chk("bp_refill_dout1", dout_of(1), 32'h0BBBB);
      chk("bp_refill_vld1", 32'(vld_of(1)), 32'd1);
      bus.din_vld = 1'b0;
      step();
      chk("bp_drain_vld1", 32'(vld_of(1)), 32'd0);
      chk("bp_drain_keep", dout_of(1), 32'h0BBBB);

      // partial frame abandoned by leaving sequence mode
      pulses = 0;
      put(21'h00021, 2'd0, 1'b1);
      step();
      put(21'h00022, 2'd0, 1'b1);
      step();
      chk("ab_dout1", dout_of(1), 32'h22);
      chk("ab_frame", 32'(bus.frame_done), 32'd0);
      bus.din_vld = 1'b0;
      bus.din_seq_mode = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         put(21'(32'h31 + i), 2'd0, 1'b1);
         step();
         chk("re_dout", dout_of(i), 32'h31 + 32'(i));
         if (bus.frame_done) pulses++;
      end
      chk("re_frame_last", 32'(bus.frame_done), 32'd1);
      chk("re_pulses", 32'(pulses), 32'd1);

      // asynchronous reset with every channel holding a word
      put(21'h00007, 2'd3, 1'b0);
      step();
      chk("ar_err_set", 32'(bus.err_sel), 32'd1);
      bus.din_vld = 1'b0;
      step();
      set_rdy(1'b0);
      for (int i = 0; i < 3; i++) begin
         put(21'(32'h41 + i), 2'd0, 1'b1);
         step();
      end
      bus.din_vld = 1'b0;
      chk("ar_all_vld", {29'd0, vld_of(2), vld_of(1), vld_of(0)}, 32'd7);
      chk("ar_frame_pre", 32'(bus.frame_done), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_vld", {29'd0, vld_of(2), vld_of(1), vld_of(0)}, 32'd0);
      chk("ar_dout0", dout_of(0), 32'd0);
      chk("ar_dout1", dout_of(1), 32'd0);
      chk("ar_dout2", dout_of(2), 32'd0);
      chk("ar_frame", 32'(bus.frame_done), 32'd0);
      chk("ar_err", 32'(bus.err_sel), 32'd0);
      step();
      rst_n = 1'b1;
      set_rdy(1'b1);
      put(21'h00051, 2'd2, 1'b1);
      step();
      chk("post_rst_dout0", dout_of(0), 32'h51);
      chk("post_rst_vld0", 32'(vld_of(0)), 32'd1);
      bus.din_vld = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/estimador_func_demux_21_3_seq.md
Name: estimador_func_demux_21_3_seq

Overview:
- Inverse of the estimator's 3:1 output multiplexer: takes one 21-bit fixed-point word stream and distributes each word to one of three registered output channels.
- Destination comes from an explicit 2-bit select (direct mode) or from an internal 0→1→2 sequencer (sequence mode), so a 3-element state vector can be scattered back into the estimator datapath.
- Sits between the serialized estimator result bus and the three per-state consumers; valid/ready on every port.

Parameters:
- DATA_WIDTH, 21, width of din and each dout_k.
- SEL_WIDTH, 2, width of din_sel; the channel count is fixed at 3.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH  input word.
- din_sel  in  SEL_WIDTH  destination in direct mode; ignored in sequence mode.
- din_seq_mode  in  1  1 = internal sequencer chooses destination; 0 = direct mode.
- din_vld  in  1  input word valid.
- din_rdy  out  1  input can accept this cycle.
- dout0, dout1, dout2  out  DATA_WIDTH each  channel data registers.
- dout0_vld, dout1_vld, dout2_vld  out  1 each  channel holds an undelivered word.
- dout0_rdy, dout1_rdy, dout2_rdy  in  1 each  consumer accepts the word.
- frame_done  out  1  one-cycle pulse after channel 2 is loaded in sequence mode.
- err_sel  out  1  sticky flag: din_sel==3 was accepted in direct mode.

Behaviour:
- Reset (ap_rst_n=0, asynchronous): all dout_k=0, dout_k_vld=0, frame_done=0, err_sel=0, seq_cnt=0. din_rdy is combinational and reads 0 while reset is asserted.
- Target decode must match the companion mux exactly:
  - direct mode: sel[1]=1 → channel 2; otherwise sel[0]=0 → channel 0, sel[0]=1 → channel 1.
  - sel=3 therefore routes to channel 2 and also sets err_sel.
  - sequence mode: target = seq_cnt (0, 1, 2).
- Each channel is a 1-deep holding register.
  - Channel k is free when dout_k_vld=0, or when dout_k_vld=1 and dout_k_rdy=1 in the same cycle (drain-and-refill).
  - din_rdy = free(target), combinational from din_sel, din_seq_mode, seq_cnt, dout_k_vld and dout_k_rdy. It must not depend on din_vld.
- Transfer occurs when din_vld & din_rdy in cycle N.
  - On the edge ending N: dout_target ← din, dout_target_vld ← 1.
  - Latency is 1 cycle.
  - Throughput is 1 word/cycle when consumers hold ready high.
- Channel drain: dout_k_vld & dout_k_rdy with no refill → dout_k_vld ← 0. dout_k keeps its last value; it is not cleared.
- Non-target channels are unaffected by input transfers. A channel may drain while another is being loaded.
- A held word must stay stable: dout_k and dout_k_vld do not change while dout_k_vld=1 and dout_k_rdy=0.
- Sequencer (seq_cnt, 2 bits, values 0..2):
  - While din_seq_mode=0: seq_cnt ← 0 each cycle.
  - While din_seq_mode=1: seq_cnt advances 0→1→2→0 on each transfer and holds otherwise.
  - Leaving sequence mode mid-frame discards the partial position. Re-entering starts at channel 0.
- frame_done ← 1 for exactly one cycle on the edge ending a sequence-mode transfer with seq_cnt=2; it is 0 otherwise. This pulse is coincident with dout2_vld rising.
- err_sel ← 1 on the edge ending a direct-mode transfer with din_sel=3. It is cleared only by reset. Sel=3 presented without a transfer does not set it.
- If din_vld=1 and din_rdy=0: no state change, including no seq_cnt advance.
- din_sel and din_seq_mode may change only while the input is not transferring. Their value in a transfer cycle is the one used.

Test Plan:
- Reset release, consumers ready, direct mode, words 0x00001/0x00002/0x00003 with sel=0/1/2 in consecutive cycles → dout0/1/2 = 0x00001/0x00002/0x00003, each vld high 1 cycle after its input. din_rdy held 1; err_sel=0.
- Direct mode, sel=3, din=0x1ABCD → dout2=0x1ABCD, dout2_vld=1, err_sel=1 and staying 1 through later valid traffic until ap_rst_n pulsed low.
- Sequence mode, 6 back-to-back words 0x10..0x15, all rdy=1 → channels receive 0x10,0x11,0x12 then 0x13,0x14,0x15. frame_done pulses exactly twice, with dout2_vld.
- Backpressure: dout1_rdy=0, fill ch1 with 0x0AAAA, then present sel=1 0x0BBBB → din_rdy=0 and dout1 stays 0x0AAAA. Raise dout1_rdy → same-cycle drain and refill, dout1=0x0BBBB next cycle. A sel=0 word presented during the stall transfers immediately.
- Sequence mode, transfer 2 words, drop din_seq_mode for 1 cycle, re-enter, send 3 words → the 3 words land on channels 0,1,2 and only the last produces frame_done.
- Assert ap_rst_n low asynchronously mid-cycle with all channels valid → all vld, dout, frame_done, err_sel go 0 immediately without a clock edge. After release, the first sequence-mode word lands on channel 0.
